// File: rtl/i2c_pkg.sv
// Shared types and widths for the i2c arbiter slice.
package i2c_pkg;

  localparam int I2C_AW = 7;
  localparam int I2C_DW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/i2c_rr_arb.sv
// Combinational round-robin grant: first asserted request at or above ptr_i, wrapping mod NREQ.
// Zero latency, no state; idx_o is the binary form of the one-hot gnt_o.
module i2c_rr_arb
  import i2c_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr_i) + k) % NREQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_arb.sv
// Round-robin sequencer sharing one i2c_master among NREQ single-byte requesters.
// Grant every >=4 cycles; requesters are held off (req_ready low) whenever not IDLE.
module i2c_arb
  import i2c_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 50000,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*I2C_AW-1:0] req_addr,
  input  logic [NREQ-1:0]        req_rw,
  input  logic [NREQ*I2C_DW-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [I2C_DW-1:0]      rsp_rdata,
  output logic                   rsp_nack,
  output logic                   rsp_tmo,
  output logic                   arb_busy,
  output logic                   mst_start,
  output logic [I2C_AW-1:0]      mst_addr,
  output logic                   mst_rw,
  output logic [I2C_DW-1:0]      mst_dfifo,
  output logic                   mst_abort,
  input  logic                   mst_busy,
  input  logic                   mst_done,
  input  logic [I2C_DW-1:0]      mst_rdata,
  input  logic                   mst_nack
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e        state_q;
  logic [IW-1:0]     ptr_q, ptr_d, gidx_q;
  logic [TW-1:0]     cnt_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [I2C_DW-1:0] rdata_q;
  logic              nack_q, tmo_q;
  logic [I2C_AW-1:0] addr_q;
  logic              rw_q;
  logic [I2C_DW-1:0] wdata_q;

  logic [NREQ-1:0]   gnt;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_any;
  logic [I2C_AW-1:0] sel_addr;
  logic              sel_rw;
  logic [I2C_DW-1:0] sel_wdata;
  logic              tmo_hit;

  i2c_rr_arb #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  always_comb begin
    sel_addr  = req_addr[int'(gnt_idx)*I2C_AW +: I2C_AW];
    sel_rw    = req_rw[gnt_idx];
    sel_wdata = req_wdata[int'(gnt_idx)*I2C_DW +: I2C_DW];
    ptr_d     = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
  end

  // start/abort are decoded in-cycle so the master sees them in ISSUE/WAIT, not one cycle late
  assign tmo_hit   = (state_q == WAIT) && (cnt_q == TW'(TIMEOUT - 1));
  assign mst_start = (state_q == ISSUE) && !mst_busy;
  assign mst_abort = tmo_hit && !mst_done;
  assign req_ready = (rstn && state_q == IDLE) ? gnt : '0;
  assign arb_busy  = (state_q != IDLE);

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_nack  = nack_q;
  assign rsp_tmo   = tmo_q;
  assign mst_addr  = addr_q;
  assign mst_rw    = rw_q;
  assign mst_dfifo = wdata_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      nack_q      <= 1'b0;
      tmo_q       <= 1'b0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            addr_q  <= sel_addr;
            rw_q    <= sel_rw;
            wdata_q <= sel_wdata;
            gidx_q  <= gnt_idx;
            ptr_q   <= ptr_d;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (!mst_busy) begin
            cnt_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + TW'(1);
          // done takes priority over a timeout landing in the same cycle
          if (mst_done) begin
            rdata_q     <= rw_q ? mst_rdata : '0;
            nack_q      <= mst_nack;
            tmo_q       <= 1'b0;
            rsp_valid_q <= {{(NREQ-1){1'b0}}, 1'b1} << gidx_q;
            state_q     <= RESP;
          end else if (tmo_hit) begin
            rdata_q     <= '0;
            nack_q      <= 1'b1;
            tmo_q       <= 1'b1;
            rsp_valid_q <= {{(NREQ-1){1'b0}}, 1'b1} << gidx_q;
            state_q     <= RESP;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arb.sv
// Scoreboard bench for i2c_arb: randomized requesters, behavioural master model, response monitor.
module tb_i2c_arb;

  localparam int NREQ  = 4;
  localparam int TMO   = 120;
  localparam int NEVER = 1 << 20;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*7-1:0] req_addr;
  logic [NREQ-1:0]   req_rw;
  logic [NREQ*8-1:0] req_wdata;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_nack, rsp_tmo, arb_busy, mst_start, mst_rw, mst_abort;
  logic [6:0]        mst_addr;
  logic [7:0]        mst_dfifo;
  logic              mst_busy, mst_done, mst_nack;
  logic [7:0]        mst_rdata;

  i2c_arb #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_nack(rsp_nack), .rsp_tmo(rsp_tmo), .arb_busy(arb_busy),
    .mst_start(mst_start), .mst_addr(mst_addr), .mst_rw(mst_rw), .mst_dfifo(mst_dfifo),
    .mst_abort(mst_abort), .mst_busy(mst_busy), .mst_done(mst_done),
    .mst_rdata(mst_rdata), .mst_nack(mst_nack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         idx;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    int         delay;
    logic [7:0] rdata;
    logic       nack;
  } txn_t;

  typedef struct {
    int         idx;
    logic [6:0] addr;
    logic [7:0] rdata;
    logic       nack;
    logic       tmo;
  } rsp_t;

  txn_t pend[NREQ];
  txn_t plan_q[$];
  rsp_t exp_q[$];
  int   grant_log[$];

  int vectors = 0;
  int miscompares = 0;
  int n_starts = 0, n_aborts = 0, n_acc = 0, n_rsp = 0;
  int mptr = 0, last_acc = -1, issued = 0;
  bit mode_all = 0, mode_auto = 0;
  bit [NREQ-1:0] acc = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic set_req(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd,
                         input int dly, input logic [7:0] rd, input logic nk);
    pend[i] = '{i, a, rw, wd, dly, rd, nk};
    req_addr[i*7 +: 7]  = a;
    req_rw[i]           = rw;
    req_wdata[i*8 +: 8] = wd;
    req_valid[i]        = 1'b1;
  endtask

  task automatic rand_req(input int i);
    int r = $urandom % 10;
    int d = (r == 0) ? NEVER : (r < 5) ? 1 + int'($urandom % 8) : int'($urandom_range(1, TMO));
    set_req(i, 7'($urandom), 1'($urandom), 8'($urandom), d, 8'($urandom), ($urandom % 4) == 0);
  endtask

  // Expected winner comes straight from the rotation rule; expected response from the plan.
  task automatic accept();
    int   g = -1;
    int   e = -1;
    txn_t t;
    rsp_t r;
    for (int k = 0; k < NREQ; k++) if (req_ready[k]) g = k;
    for (int k = 0; k < NREQ; k++) begin
      int j = (mptr + k) % NREQ;
      if (e < 0 && req_valid[j]) e = j;
    end
    chk("ready_onehot", $onehot(req_ready), 1);
    chk("ready_only_idle", arb_busy, 0);
    chk("grant_idx", g, e);
    if (last_acc >= 0) chk("grant_spacing_ge4", (cyc - last_acc) >= 4, 1);
    last_acc = cyc;
    mptr = (g + 1) % NREQ;
    grant_log.push_back(g);
    t = pend[g];
    plan_q.push_back(t);
    r.idx   = g;
    r.addr  = t.addr;
    r.tmo   = t.delay > TMO;
    r.nack  = r.tmo ? 1'b1 : t.nack;
    r.rdata = (r.tmo || !t.rw) ? 8'h00 : t.rdata;
    exp_q.push_back(r);
    acc[g] = 1'b1;
    n_acc++;
  endtask

  // One clock: entered and left at a falling edge.
  task automatic step();
    for (int i = 0; i < NREQ; i++)
      if (acc[i]) begin req_valid[i] = 1'b0; acc[i] = 1'b0; end
    if (mode_all)
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i]) set_req(i, 7'(16 + i), 1'b0, 8'(i), 3, 8'h00, 1'b0);
    if (mode_auto) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && issued < 40 && ($urandom % 3) == 0) begin
          rand_req(i);
          issued++;
        end else if (req_valid[i] && ($urandom % 16) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      mst_busy = ($urandom % 4) == 0;
    end
    #1;
    if (rstn && req_ready != '0) accept();
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((exp_q.size() > 0 || req_valid != '0) && k < budget) begin step(); k++; end
    chk("drain_in_budget", exp_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_nack"}, rsp_nack, 0);
    chk({tag, "_rsp_tmo"}, rsp_tmo, 0);
    chk({tag, "_arb_busy"}, arb_busy, 0);
    chk({tag, "_mst_start"}, mst_start, 0);
    chk({tag, "_mst_abort"}, mst_abort, 0);
    chk({tag, "_mst_addr"}, mst_addr, 0);
    chk({tag, "_mst_rw"}, mst_rw, 0);
    chk({tag, "_mst_dfifo"}, mst_dfifo, 0);
  endtask

  // Master model: completes each started transaction after its planned delay, injects stray dones.
  initial begin
    txn_t cur;
    bit   active = 0;
    int   cs = 0;
    mst_done = 1'b0; mst_rdata = 8'h00; mst_nack = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rstn) begin
        active = 0; mst_done = 1'b0; mst_nack = 1'b0;
      end else begin
        if (active && (cyc - cs) == cur.delay) begin
          mst_done = 1'b1; mst_rdata = cur.rdata; mst_nack = cur.nack; active = 0;
        end else if (!active && ($urandom % 8) == 0) begin
          mst_done = 1'b1; mst_rdata = 8'($urandom); mst_nack = 1'($urandom);
        end else begin
          mst_done = 1'b0; mst_rdata = 8'($urandom); mst_nack = 1'b0;
        end
        #1;
        if (mst_abort) begin
          chk("abort_only_on_timeout", active && cur.delay > TMO, 1);
          chk("abort_delay", cyc - cs, TMO);
          active = 0;
          n_aborts++;
        end
        if (mst_start) begin
          chk("start_not_busy", mst_busy, 0);
          chk("start_planned", plan_q.size() > 0, 1);
          if (plan_q.size() > 0) begin
            cur = plan_q.pop_front();
            chk("mst_addr", mst_addr, cur.addr);
            chk("mst_rw", mst_rw, cur.rw);
            chk("mst_dfifo", mst_dfifo, cur.wdata);
            active = 1;
            cs = cyc;
          end
          n_starts++;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  initial begin
    rsp_t e;
    logic [7:0] lr = 0, pr = 0;
    logic ln = 0, lt = 0, pn = 0, pt = 0;
    forever begin
      @(negedge clk);
      #4;
      if (!rstn) begin
        lr = 0; ln = 0; lt = 0;
      end else if (rsp_valid != '0) begin
        chk("rsp_hold_rdata", pr, lr);
        chk("rsp_hold_nack", pn, ln);
        chk("rsp_hold_tmo", pt, lt);
        chk("rsp_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rsp_valid", rsp_valid, 1 << e.idx);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_nack", rsp_nack, e.nack);
          chk("rsp_tmo", rsp_tmo, e.tmo);
          chk("rsp_mst_addr_held", mst_addr, e.addr);
          lr = e.rdata; ln = e.nack; lt = e.tmo;
        end
        n_rsp++;
      end
      pr = rsp_rdata; pn = rsp_nack; pt = rsp_tmo;
    end
  end

  initial begin
    #800_000;
    miscompares++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int k, s0, a0;
    rstn = 1'b0;
    req_valid = '0; req_addr = '0; req_rw = '0; req_wdata = '0; mst_busy = 1'b0;
    repeat (3) @(negedge clk);
    req_valid = '1;
    #1;
    check_zero("reset");
    req_valid = '0;
    @(negedge clk);
    rstn = 1'b1;

    // fairness: everyone valid continuously
    grant_log.delete();
    mode_all = 1;
    k = 0;
    while (grant_log.size() < 5 && k < 300) begin step(); k++; end
    mode_all = 0;
    for (int i = 0; i < NREQ; i++) if (!acc[i]) req_valid[i] = 1'b0;
    chk("fair_count", grant_log.size(), 5);
    for (int i = 0; i < 5; i++) if (i < grant_log.size()) chk("fair_order", grant_log[i], i % NREQ);
    drain(400);

    // single write, read data returned by master must be dropped
    s0 = n_starts;
    set_req(0, 7'h50, 1'b0, 8'h5a, 100, 8'hff, 1'b0);
    drain(400);
    chk("wr_one_start", n_starts - s0, 1);

    // read with NACK
    set_req(2, 7'h21, 1'b1, 8'h00, 7, 8'hc3, 1'b1);
    drain(200);

    // timeout: master never completes
    a0 = n_aborts;
    set_req(3, 7'h33, 1'b1, 8'h11, NEVER, 8'h99, 1'b0);
    drain(400);
    chk("tmo_one_abort", n_aborts - a0, 1);

    // busy hold, done lands exactly on the timeout cycle
    mst_busy = 1'b1;
    s0 = n_starts; a0 = n_acc;
    set_req(1, 7'h44, 1'b0, 8'hbe, TMO, 8'h00, 1'b0);
    k = 0;
    while (n_acc == a0 && k < 20) begin step(); k++; end
    repeat (10) step();
    chk("busy_no_start", n_starts - s0, 0);
    chk("busy_holds_issue", arb_busy, 1);
    mst_busy = 1'b0;
    drain(400);
    chk("busy_one_start", n_starts - s0, 1);

    // reset during WAIT
    s0 = n_starts;
    set_req(2, 7'h2a, 1'b1, 8'h00, NEVER, 8'h00, 1'b0);
    k = 0;
    while (n_starts == s0 && k < 50) begin step(); k++; end
    repeat (5) step();
    chk("rst_in_wait_busy", arb_busy, 1);
    rstn = 1'b0;
    req_valid = '0;
    acc = '0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    exp_q.delete(); plan_q.delete(); grant_log.delete();
    mptr = 0; last_acc = -1;
    rstn = 1'b1;
    set_req(1, 7'h15, 1'b0, 8'h5e, 5, 8'h00, 1'b0);
    set_req(3, 7'h37, 1'b1, 8'h00, 4, 8'h77, 1'b0);
    drain(200);
    chk("post_rst_grants", grant_log.size(), 2);
    if (grant_log.size() > 0) chk("post_rst_ptr0", grant_log[0], 1);

    // randomized traffic with random busy and withdrawals
    mode_auto = 1;
    issued = 0;
    k = 0;
    while (issued < 40 && k < 20000) begin step(); k++; end
    mode_auto = 0;
    mst_busy = 1'b0;
    drain(20000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_arb.md
Name: i2c_arb

Overview:
- Round-robin arbiter and sequencer that shares one i2c_master between NREQ on-chip requesters.
- Each request is a single-byte transaction: 7-bit slave address, R/W bit and one write byte.
- Issues the request to the master, waits for completion with a timeout, and returns read data and status to the winning requester.
- Sits between client logic and i2c_master in the clk_100m domain.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 50000, max cycles waited for mst_done after mst_start (500 us at 100 MHz).
- TW, $clog2(TIMEOUT+1), timeout counter width (derived; do not override).

Ports:
- clk  in  1  system clock (clk_100m).
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_addr  in  NREQ*7  flattened slave addresses; requester i uses bits [7i+6:7i].
- req_rw  in  NREQ  1 = read, 0 = write.
- req_wdata  in  NREQ*8  flattened write bytes.
- req_ready  out  NREQ  one-hot accept; a request is taken when valid & ready.
- rsp_valid  out  NREQ  one-hot, one-cycle response pulse.
- rsp_rdata  out  8  read byte; 0 for writes.
- rsp_nack  out  1  slave NACK seen.
- rsp_tmo  out  1  transaction timed out.
- arb_busy  out  1  high whenever state != IDLE.
- mst_start  out  1  one-cycle start pulse to the master.
- mst_addr  out  7  latched slave address.
- mst_rw  out  1  latched R/W.
- mst_dfifo  out  8  latched write byte.
- mst_abort  out  1  one-cycle abort pulse on timeout.
- mst_busy  in  1  master busy.
- mst_done  in  1  one-cycle completion pulse.
- mst_rdata  in  8  read byte, valid with mst_done.
- mst_nack  in  1  NACK flag, valid with mst_done.

Behaviour:
- Reset: every output is 0, round-robin pointer = 0, state = IDLE, counter = 0.
- States are IDLE, ISSUE, WAIT and RESP.
- IDLE:
  - Grant goes to the first asserted req_valid searching from the pointer upward, wrapping mod NREQ.
  - req_ready[g] is combinational and asserted only in IDLE.
  - On grant: latch addr/rw/wdata into mst_* and the index g, set pointer <= (g+1) mod NREQ, go to ISSUE.
  - No request pending: stay in IDLE.
- ISSUE:
  - If mst_busy = 0: mst_start = 1 for this cycle, clear the counter, go to WAIT.
  - If mst_busy = 1: mst_start = 0 and stay in ISSUE (no timeout while here).
- WAIT:
  - Counter increments each cycle.
  - mst_done = 1: capture mst_rdata (forced to 0 if rw = 0) and mst_nack, clear tmo, go to RESP.
  - Else, counter == TIMEOUT-1: pulse mst_abort, set rsp_tmo = 1, rsp_nack = 1, rdata = 0, go to RESP.
  - mst_done and timeout in the same cycle: done wins, no abort.
- RESP: rsp_valid[g] = 1 for one cycle with rsp_rdata/nack/tmo stable, then go to IDLE.
- rsp_rdata, rsp_nack and rsp_tmo hold their value until the next RESP.
- mst_addr, mst_rw and mst_dfifo are stable from ISSUE through RESP and hold their value in IDLE.
- mst_done outside WAIT is ignored.
- A requester dropping req_valid before ready has no effect; a granted request cannot be withdrawn.
- Minimum turnaround: IDLE→ISSUE→WAIT(≥1)→RESP→IDLE, i.e. a grant every ≥4 cycles.
- Reset asserted mid-transaction: immediately return to IDLE with all outputs 0. No mst_abort is issued; the master shares rstn.

Decomposition:
- Package i2c_pkg holds:
  - the state encoding (IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3);
  - I2C_AW = 7 and I2C_DW = 8.
- Sub-module i2c_rr_arb: combinational round-robin grant (req vector and pointer in, one-hot grant plus encoded index out). It is reused by future shared-bus blocks.

Test Plan:
- Single write: req 0 with addr 7'h50, rw = 0, wdata 8'h5a; master model returns done after 100 cycles with nack = 0 → mst_dfifo = 8'h5a, one mst_start, rsp_valid = 4'b0001, rdata = 0, nack = 0, tmo = 0.
- Round-robin fairness: all four requesters valid continuously from reset → grant order 0,1,2,3,0; each req_ready pulse precedes its rsp_valid.
- Read + NACK: req 2 with rw = 1; the model returns rdata 8'hc3 with nack = 1 → rsp_valid = 4'b0100, rsp_rdata = 8'hc3, rsp_nack = 1.
- Timeout: TIMEOUT = 20 and the model never asserts done → mst_abort pulses exactly 20 cycles after mst_start; rsp_tmo = 1 and rsp_nack = 1 follow one cycle later.
- Busy hold: mst_busy = 1 for 10 cycles after a grant → no mst_start until busy falls, then exactly one start; the timeout counter does not run during the hold.
- Reset mid-WAIT: assert rstn = 0 for 2 cycles during WAIT → all outputs 0, pointer 0, and a new req 1 is serviced normally after release.
